// File: rtl/bin_to_bcd_pkg.sv
// Shared display definitions: converter FSM encoding, double-dabble adjust
// constants and a helper for the largest value a run of BCD digits can show.
package bin_to_bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  function automatic logic [63:0] max_bcd_value(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_adj_digit.sv
// One double-dabble digit correction: add 3 to a BCD digit of 5 or more so
// the following left shift carries correctly into the next decade.
module bcd_adj_digit
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] value,
  output logic [3:0] adjusted
);

  assign adjusted = (value >= ADJ_THRESH) ? (value + ADJ_ADD) : value;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock,
// with saturation to all nines and a leading-zero blanking mask.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int          BW      = 4 * DIGITS;
  localparam int          CW      = $clog2(IN_W + 1);
  localparam logic [63:0] MAX_VAL = max_bcd_value(DIGITS);

  bcd_state_t        state;
  bcd_state_t        next_state;
  logic [IN_W-1:0]   shift_reg;
  logic [IN_W-1:0]   latched;
  logic [BW-1:0]     scratch;
  logic [BW-1:0]     adjusted;
  logic [BW-1:0]     scratch_next;
  logic [CW-1:0]     count;
  logic              last_shift;
  logic              over;
  logic              leading;
  logic [DIGITS-1:0] blank_value;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj_digit u_adj (
      .value    (scratch[4*g +: 4]),
      .adjusted (adjusted[4*g +: 4])
    );
  end

  assign scratch_next = {adjusted[BW-2:0], shift_reg[IN_W-1]};
  assign last_shift   = (state == SHIFT) && (count == CW'(IN_W - 1));
  assign over         = 64'(latched) > MAX_VAL;
  assign busy         = (state == SHIFT);

  // Digit i blanks only while every more significant digit is also zero.
  always_comb begin
    blank_value = '0;
    leading     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      leading        = leading && (scratch_next[4*i +: 4] == 4'd0);
      blank_value[i] = leading;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_shift) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      latched   <= '0;
      scratch   <= '0;
      count     <= '0;
      done      <= 1'b0;
      bcd       <= '0;
      ovf       <= 1'b0;
      blank     <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            latched   <= bin;
            scratch   <= '0;
            count     <= '0;
          end
        end
        SHIFT: begin
          scratch   <= scratch_next;
          shift_reg <= shift_reg << 1;
          count     <= count + 1'b1;
          // Final shift: publish the result (saturated when out of range).
          if (last_shift) begin
            done <= 1'b1;
            if (over) begin
              bcd   <= {DIGITS{4'h9}};
              ovf   <= 1'b1;
              blank <= '0;
            end else begin
              bcd   <= scratch_next;
              ovf   <= 1'b0;
              blank <= blank_value;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed self-checking bench for bin_to_bcd: reset, latency, boundaries,
// start-while-busy, mid-conversion reset and a strided back-to-back sweep.
module tb_bin_to_bcd;

  localparam int IN_W   = 14;
  localparam int DIGITS = 4;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic [IN_W-1:0]   bin     = '0;
  logic              busy;
  logic              done;
  logic [15:0]       bcd;
  logic              ovf;
  logic [3:0]        blank;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bin_to_bcd #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .ovf     (ovf),
    .blank   (blank)
  );

  function automatic logic [15:0] model_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] model_blank(input int v);
    if (v > 9999) return 4'b0000;
    if (v < 10)   return 4'b1110;
    if (v < 100)  return 4'b1100;
    if (v < 1000) return 4'b1000;
    return 4'b0000;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives a request and returns just after the accepting edge, start still high.
  task automatic apply_stimulus(input int v);
    @(negedge clock);
    bin   = IN_W'(v);
    start = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Edge count includes the accepting edge; bounded so a dead DUT cannot hang.
  task automatic wait_done(output int edges);
    edges = 1;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
    end
  endtask

  task automatic check_result(input string tag, input int v, input int edges);
    check_output({tag, ".done"},    64'(done),           64'(1));
    check_output({tag, ".latency"}, 64'(edges),          64'(IN_W + 1));
    check_output({tag, ".busy"},    64'(busy),           64'(0));
    check_output({tag, ".bcd"},     64'(bcd),            64'(model_bcd(v)));
    check_output({tag, ".ovf"},     64'(ovf),            64'(v > 9999));
    check_output({tag, ".blank"},   64'(blank),          64'(model_blank(v)));
  endtask

  task automatic convert(input string tag, input int v);
    int e;
    apply_stimulus(v);
    check_output({tag, ".busy_at_accept"}, 64'(busy), 64'(1));
    check_output({tag, ".done_at_accept"}, 64'(done), 64'(0));
    start = 1'b0;
    wait_done(e);
    check_result(tag, v, e);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e;
    int dones;
    int vals[$];

    #12;
    check_output("reset.busy",  64'(busy),  64'(0));
    check_output("reset.done",  64'(done),  64'(0));
    check_output("reset.bcd",   64'(bcd),   64'(0));
    check_output("reset.ovf",   64'(ovf),   64'(0));
    check_output("reset.blank", 64'(blank), 64'(4'b1110));
    @(negedge clock);
    reset_n = 1'b1;

    convert("v1234", 1234);
    convert("v0", 0);
    convert("v7", 7);
    convert("v305", 305);
    convert("v9999", 9999);
    convert("v10000", 10000);
    convert("v16383", 16383);

    // Start pulses during busy must not disturb the running conversion.
    apply_stimulus(42);
    start = 1'b0;
    bin   = IN_W'(77);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      start = (i == 3 || i == 7) ? 1'b1 : 1'b0;
      @(posedge clock);
      #1;
      if (done) begin
        dones++;
        check_output("busy_ignore.bcd", 64'(bcd), 64'(16'h0042));
      end
    end
    start = 1'b0;
    check_output("busy_ignore.dones", 64'(dones), 64'(1));
    check_output("busy_ignore.idle",  64'(busy),  64'(0));
    check_output("busy_ignore.hold",  64'(bcd),   64'(16'h0042));

    // Start held through done is taken on the very next edge.
    apply_stimulus(42);
    bin = IN_W'(77);
    wait_done(e);
    check_result("held42", 42, e);
    @(posedge clock);
    #1;
    check_output("held.reaccept_busy", 64'(busy), 64'(1));
    check_output("held.reaccept_done", 64'(done), 64'(0));
    start = 1'b0;
    wait_done(e);
    check_result("held77", 77, e);

    // Reset in the middle of a conversion.
    apply_stimulus(5678);
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midreset.busy",  64'(busy),  64'(0));
    check_output("midreset.done",  64'(done),  64'(0));
    check_output("midreset.bcd",   64'(bcd),   64'(0));
    check_output("midreset.ovf",   64'(ovf),   64'(0));
    check_output("midreset.blank", 64'(blank), 64'(4'b1110));
    @(negedge clock);
    reset_n = 1'b1;
    dones = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (done) dones++;
    end
    check_output("midreset.no_done", 64'(dones), 64'(0));
    convert("v5678", 5678);

    // Back-to-back sweep with start held high, strided to bound run time.
    for (int v = 0; v <= 9999; v += 7) vals.push_back(v);
    vals.push_back(9999);
    @(negedge clock);
    bin   = IN_W'(vals[0]);
    start = 1'b1;
    @(posedge clock);
    #1;
    for (int k = 0; k < vals.size(); k++) begin
      if (k + 1 < vals.size()) bin = IN_W'(vals[k+1]);
      else start = 1'b0;
      wait_done(e);
      check_result($sformatf("sweep%0d", vals[k]), vals[k], e);
      @(posedge clock);
      #1;
    end
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 SHALL have parameter IN_W, default 14: width of the binary input.
REQ-002 SHALL have parameter DIGITS, default 4: number of BCD digits produced; output width 4*DIGITS.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clock  input  1: rising-edge system clock.
REQ-005 SHALL have port reset_n  input  1: asynchronous active-low reset.
REQ-006 SHALL have port start  input  1: request a conversion of bin; sampled only in IDLE.
REQ-007 SHALL have port bin  input  IN_W: unsigned binary value, sampled on the accepting edge.
REQ-008 SHALL have port busy  output  1: high while a conversion is in progress.
REQ-009 SHALL have port done  output  1: one-cycle pulse when bcd/ovf/blank update.
REQ-010 SHALL have port bcd  output  4*DIGITS: packed BCD, digit 0 in bits [3:0]; directly feeds seg_driver bin.
REQ-011 SHALL have port ovf  output  1: last accepted value exceeded 10^DIGITS-1.
REQ-012 SHALL have port blank  output  DIGITS: leading-zero mask, bit i set when digit i is a suppressible leading zero.

Function
REQ-013 SHALL implement an FSM with states IDLE and SHIFT.
REQ-014 SHALL, in IDLE with start=1 on an edge, latch bin into a shift register, clear the BCD scratch and the bit counter, and enter SHIFT.
REQ-015 SHALL, on each SHIFT edge: add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one, then increment the counter.
REQ-016 SHALL perform exactly IN_W shift edges; on the IN_W-th it SHALL load the outputs, pulse done, and return to IDLE.
REQ-017 SHALL have a latency of IN_W+1 edges from the accepting edge to done high (15 with defaults), for a throughput of one conversion per IN_W+1 cycles.
REQ-018 SHALL hold busy=1 from the edge after acceptance until the edge that asserts done; busy and done SHALL never both be high.
REQ-019 SHALL ignore start while busy; a start held high in the cycle done is high SHALL be accepted on the next edge.
REQ-020 SHALL, when the accepted bin > 10^DIGITS-1, load bcd with all digits 9 and set ovf=1; otherwise ovf=0.
REQ-021 SHALL compute blank[i]=1 when digits DIGITS-1..i are all zero, for i>=1; blank[0] SHALL always be 0 so that value 0 shows "0".
REQ-022 SHALL force blank=0 when ovf=1.
REQ-023 SHALL hold bcd, ovf and blank stable between done pulses.
REQ-024 SHALL use an overflow check evaluated on the latched input, at full IN_W width, with no truncation.

Reset
REQ-025 SHALL, on reset_n low at any time including mid-conversion, go to IDLE, abort the conversion, and clear busy, done, bcd, ovf and the internal registers to 0; blank SHALL reset to {DIGITS-1 ones, 0}.
REQ-026 SHALL require start low for at least one edge after reset release; start high on the first edge after release SHALL be accepted normally.

Structure
REQ-027 SHALL place the FSM state encoding and the add-3 threshold constant in a shared display package, also used by seg_driver-adjacent blocks.
REQ-028 SHALL implement the per-digit "add 3 if >= 5" logic as sub-module bcd_adj_digit (4-bit in, 4-bit out), instantiated DIGITS times.
REQ-029 SHALL size the bit counter as clog2(IN_W+1) bits.

Verification
REQ-030 SHALL verify: reset, start with bin=1234 -> done high exactly 15 cycles after the accepting edge, bcd=16'h1234, ovf=0, blank=4'b0000.
REQ-031 SHALL verify: bin=0 -> bcd=16'h0000, blank=4'b1110, ovf=0.
REQ-032 SHALL verify: bin=9999 -> bcd=16'h9999, ovf=0; bin=10000 and bin=16383 -> bcd=16'h9999, ovf=1, blank=0.
REQ-033 SHALL verify: bin=42 accepted, then start pulses with bin=77 during busy -> result is 16'h0042 with a single done pulse; start held through done -> next result is 16'h0077.
REQ-034 SHALL verify: reset_n asserted 5 cycles into a conversion of 5678 -> busy=0, bcd=0 immediately, no done pulse; a fresh conversion of 5678 then yields 16'h5678.
REQ-035 SHALL verify: a back-to-back sweep of 0..9999 with start held high matches a reference model on every done pulse.
